ldc: RTL and testbench
======================

# ldc

The `LDC` block is a 64-entry × 20-bit register bank that performs load-constant operations. It captures a 64-word bank image when reset is asserted. On every clock cycle after that, it writes constant `C` into entry `R`. It reports the written value, the entry's previous bank contents and the entry's original image word. It sits in the processor datapath as the load-constant (LDC) execution path into the memory bank.

## Interface
Parameters: none. Widths are fixed: 64 entries, 20-bit words, 6-bit index.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `a` input 64×20 (packed `[63:0][19:0]`, 1280 bits): bank image; word i = `a[i]` = bits `[20i+19:20i]`.
- `C` input 20: constant to load.
- `R` input 6: destination entry index, 0–63.
- `out` output 20: value written by the last operation.
- `buff1` output 20: bank contents of entry `R` immediately before the last write.
- `buff2` output 20: image word `a[R]` sampled at the last operation.

## Operation
- Internal state is `mem[0..63]`, 20 bits each. No other architectural state.
- **Reset** (rising edge with `rst`=1):
  - `mem[i]` ← `a[i]` for all i.
  - `out`, `buff1`, `buff2` ← 0.
  - No write of `C` occurs.
- **Normal cycle** (rising edge with `rst`=0), all assignments use pre-edge values:
  - `mem[R]` ← `C`.
  - `out` ← `C`.
  - `buff1` ← `mem[R]` (old value, before this edge's write).
  - `buff2` ← `a[R]`.
- There is no enable: a write happens on every non-reset edge.
- Entries other than `R` hold their values.
- All 64 index values are legal. No wrap-around or out-of-range case exists.
- Changes to `a` after reset do not affect `mem`. They only affect `buff2`.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Back-to-back writes to the same `R`: `buff1` on the second cycle equals `C` from the first cycle. There is no bypass beyond that.
- Reset in the middle of a sequence:
  - All prior writes are discarded.
  - The bank reloads from the current `a`.
  - Outputs go to 0 on that edge.
- Reset takes priority over any simultaneous write.
- Before the first reset, `mem` and the outputs are undefined. Verification must apply reset first.

## Test plan
Common setup: `a[i]`=i for all i, reset applied for one edge.

- **Reset:** after the reset edge, `out`=`buff1`=`buff2`=0.
- **Write entry 0:** `R`=0, `C`=0, one edge → `out`=0, `buff1`=0, `buff2`=0.
- **Write entry 1:** `R`=1, `C`=0 → `out`=0, `buff1`=1, `buff2`=1. A following `R`=1, `C`=0xABCDE → `out`=0xABCDE, `buff1`=0, `buff2`=1.
- **Index decode:** `R`=32, then 48, then 63, each with `C`=0 → `buff1`/`buff2` = 32/32, 48/48, 63/63 in turn; `out`=0 each cycle.
- **Reset mid-sequence:** after the writes above, assert reset for one edge, then `R`=1, `C`=5 → `buff1`=1 (image restored), `out`=5.
- **Reset priority:** `rst`=1 with `R`=2, `C`=0xFFFFF on the same edge → outputs 0. Next `R`=2, `C`=0 → `buff1`=2.

Source files
------------

// File: rtl/ldc_if.sv
// Load-constant bank port bundle: bank image, constant and index in; registered results out.
interface ldc_if;
    logic [63:0][19:0] a;
    logic [19:0]       C;
    logic [5:0]        R;
    logic [19:0]       out;
    logic [19:0]       buff1;
    logic [19:0]       buff2;

    modport master (
        output a, C, R,
        input  out, buff1, buff2
    );

    modport slave (
        input  a, C, R,
        output out, buff1, buff2
    );
endinterface

// File: rtl/ldc.sv
// 64x20 load-constant bank: reset loads the image from a, and every other edge writes C into entry R.
// Latency is 1 cycle with all outputs registered; there is no backpressure, so a write occurs on every non-reset edge.
module ldc (
    input  logic clk,
    input  logic rst,
    ldc_if.slave bus
);
    logic [19:0] mem [64];
    logic [19:0] out_q;
    logic [19:0] buff1_q;
    logic [19:0] buff2_q;

    // Reset outranks the write: the whole bank reloads from the current image.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= bus.a[i];
            end
            out_q   <= '0;
            buff1_q <= '0;
            buff2_q <= '0;
        end else begin
            mem[bus.R] <= bus.C;
            out_q      <= bus.C;
            buff1_q    <= mem[bus.R];
            buff2_q    <= bus.a[bus.R];
        end
    end

    assign bus.out   = out_q;
    assign bus.buff1 = buff1_q;
    assign bus.buff2 = buff2_q;
endmodule

// File: tb/tb_ldc.sv
// Self-checking bench for ldc: a reference model pushes expected results, and a negedge monitor pops and compares them.
module tb_ldc;
    logic clk = 1'b0;
    logic rst;
    ldc_if bus ();

    ldc dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] out;
        logic [19:0] buff1;
        logic [19:0] buff2;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [19:0] ref_mem [64];
    logic [19:0] img     [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic drive_img();
        for (int i = 0; i < 64; i++) bus.a[i] = img[i];
    endtask

    // Reference behaviour: reset copies the image into the bank; otherwise report old contents and store C.
    task automatic op(input bit r, input logic [5:0] idx, input logic [19:0] c);
        exp_t e;
        rst    = r;
        bus.R  = idx;
        bus.C  = c;
        drive_img();
        if (r) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = img[i];
            e.out   = '0;
            e.buff1 = '0;
            e.buff2 = '0;
        end else begin
            e.out        = c;
            e.buff1      = ref_mem[idx];
            e.buff2      = img[idx];
            ref_mem[idx] = c;
        end
        e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("out",   bus.out,   mon_e.out);
            check("buff1", bus.buff1, mon_e.buff1);
            check("buff2", bus.buff2, mon_e.buff2);
        end
    end

    initial begin
        logic [5:0] last_r;
        logic [5:0] r_idx;
        rst   = 1'b0;
        bus.C = '0;
        bus.R = '0;
        for (int i = 0; i < 64; i++) img[i] = 20'(i);
        drive_img();
        @(posedge clk);
        #1;

        // Directed sequence with image word i = i.
        op(1'b1, 6'd0,  20'h00000);
        op(1'b0, 6'd0,  20'h00000);
        op(1'b0, 6'd1,  20'h00000);
        op(1'b0, 6'd1,  20'hABCDE);
        op(1'b0, 6'd32, 20'h00000);
        op(1'b0, 6'd48, 20'h00000);
        op(1'b0, 6'd63, 20'h00000);
        op(1'b1, 6'd7,  20'h12345);
        op(1'b0, 6'd1,  20'h00005);
        op(1'b1, 6'd2,  20'hFFFFF);
        op(1'b0, 6'd2,  20'h00000);

        // Random traffic: image changes after reset affect only buff2, with frequent repeats of the same index.
        last_r = 6'd2;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < 64; i++) img[i] = 20'($urandom);
            end
            r_idx = ($urandom_range(0, 2) == 0) ? last_r : 6'($urandom_range(0, 63));
            op($urandom_range(0, 19) == 0, r_idx, 20'($urandom));
            last_r = r_idx;
        end

        repeat (4) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
